vram_arbiter: RTL and testbench

Single-port video RAM arbiter for the VDP. It shares one synchronous 8-bit SRAM between two requesters: the display fetch path, which has strict priority and fixed latency, and the CPU data port, which has posted writes and blocking reads. The block sits between the VDP register/CPU logic and the VRAM pins. It also reports CPU stalls back to the bus so the CPU can be held off.

---
 rtl/vram_arbiter_if.sv | 33 +++
 rtl/vram_arbiter.sv | 80 ++++++++
 tb/tb_vram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display, CPU and SRAM signal bundle for the VRAM arbiter.
interface vram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [7:0]        disp_rdata;
    logic              disp_valid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              cpu_wait;
    logic              cpu_starved;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  disp_rdata, disp_valid, cpu_ack, cpu_rdata, cpu_wait, cpu_starved,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output disp_rdata, disp_valid, cpu_ack, cpu_rdata, cpu_wait, cpu_starved,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter; display fetch has strict priority,
// CPU writes are posted through a one-entry buffer and CPU reads block.
module vram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input logic           clk,
    input logic           reset,
    vram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {R_IDLE, R_ISSUED, R_DATA} r_state_t;

    r_state_t          r_state, r_next;
    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              disp_issued, disp_data;
    logic [7:0]        starve_cnt;
    logic              cpu_live, wr_accept, wr_direct, drain, rd_grant, pending;

    always_comb begin
        cpu_live  = bus.cpu_req & ~bus.cpu_ack;
        wr_accept = cpu_live & bus.cpu_we & ~buf_full;
        wr_direct = wr_accept & ~bus.disp_req;
        drain     = buf_full & ~bus.disp_req;
        rd_grant  = cpu_live & ~bus.cpu_we & ~buf_full & ~bus.disp_req & (r_state == R_IDLE);
        pending   = cpu_live & (r_state == R_IDLE) & ~wr_accept & ~rd_grant;
        r_next    = r_state == R_ISSUED ? R_DATA :
                    r_state == R_DATA   ? R_IDLE :
                    rd_grant            ? R_ISSUED : R_IDLE;
    end

    assign bus.cpu_wait    = bus.cpu_req & ~bus.cpu_ack;
    assign bus.cpu_starved = starve_cnt >= 8'(STARVE_LIMIT);

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= R_IDLE;
        else        r_state <= r_next;

    // A write that finds the slot free bypasses the buffer so it hits mem_we in the ack cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full       <= 1'b0;
            buf_addr       <= '0;
            buf_data       <= '0;
            disp_issued    <= 1'b0;
            disp_data      <= 1'b0;
            starve_cnt     <= '0;
            bus.disp_rdata <= '0;
            bus.disp_valid <= 1'b0;
            bus.cpu_ack    <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.mem_addr   <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_wdata  <= '0;
        end else begin
            disp_issued    <= bus.disp_req;
            disp_data      <= disp_issued;
            bus.disp_valid <= disp_data;
            if (disp_data) bus.disp_rdata <= bus.mem_rdata;
            bus.cpu_ack    <= wr_accept | (r_state == R_DATA);
            if (r_state == R_DATA) bus.cpu_rdata <= bus.mem_rdata;
            if (wr_accept & bus.disp_req) begin
                buf_full <= 1'b1;
                buf_addr <= bus.cpu_addr;
                buf_data <= bus.cpu_wdata;
            end else if (drain) begin
                buf_full <= 1'b0;
            end
            bus.mem_we    <= wr_direct | drain;
            bus.mem_addr  <= bus.disp_req          ? bus.disp_addr :
                             drain                 ? buf_addr      :
                             wr_direct | rd_grant  ? bus.cpu_addr  : bus.mem_addr;
            bus.mem_wdata <= drain     ? buf_data      :
                             wr_direct ? bus.cpu_wdata : bus.mem_wdata;
            starve_cnt    <= !pending             ? 8'd0       :
                             starve_cnt == 8'hFF  ? starve_cnt : starve_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of display streaming, posted writes, reads,
// contention/starvation, back-to-back writes and reset in mid-transaction.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sram [0:65535];
    logic [44:0] outs;
    logic        p_live, p_we;
    logic [15:0] p_addr;
    logic [7:0]  p_wdata;

    vram_arbiter_if #(.ADDR_W(16)) bus ();

    vram_arbiter #(.ADDR_W(16), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign outs = {bus.disp_rdata, bus.disp_valid, bus.cpu_ack, bus.cpu_rdata, bus.cpu_wait,
                   bus.cpu_starved, bus.mem_addr, bus.mem_we, bus.mem_wdata};

    // Synchronous SRAM: read-first, data appears the cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= sram[bus.mem_addr];
    end

    // CPU side must hold its request stable until it is acknowledged.
    always @(posedge clk) begin
        if (reset && p_live && !bus.cpu_ack)
            assert (bus.cpu_req && bus.cpu_we == p_we && bus.cpu_addr == p_addr && bus.cpu_wdata == p_wdata)
            else $error("FAIL cpu_stable: request dropped or changed before cpu_ack");
        p_live  <= reset && bus.cpu_req && !bus.cpu_ack;
        p_we    <= bus.cpu_we;
        p_addr  <= bus.cpu_addr;
        p_wdata <= bus.cpu_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dr, input logic [15:0] da, input logic cr, input logic cw,
                         input logic [15:0] ca, input logic [7:0] cd);
        bus.disp_req  = dr;
        bus.disp_addr = da;
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        repeat (n) tick;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        tick;
        tick;
        reset = 1'b1;
        tick;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL idle_after_reset: got %h expected 0", outs); end
    endtask

    task automatic test_display;
        logic ev;
        for (int c = 0; c < 20; c++) begin
            drive(c < 16, 16'(c), 1'b0, 1'b0, 16'h0, 8'h0);
            #1;
            ev = (c >= 3 && c < 19);
            checks++;
            if (bus.disp_valid !== ev) begin
                errors++; $display("FAIL disp_valid c%0d: got %b expected %b", c, bus.disp_valid, ev);
            end
            if (ev) begin
                checks++;
                if (bus.disp_rdata !== 8'(c - 3)) begin
                    errors++; $display("FAIL disp_rdata c%0d: got %h expected %h", c, bus.disp_rdata, 8'(c - 3));
                end
            end
            if (c >= 1 && c < 17) begin
                checks++;
                if (bus.mem_addr !== 16'(c - 1) || bus.mem_we !== 1'b0) begin
                    errors++; $display("FAIL disp_mem c%0d: got addr %h we %b expected addr %h we 0", c, bus.mem_addr, bus.mem_we, 16'(c - 1));
                end
            end
            tick;
        end
        idle(4);
    endtask

    task automatic test_write_read;
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 16'h0, c == 0 || (c >= 2 && c < 5), c == 0, 16'h1234, 8'hA5);
            #1;
            if (c == 0) begin
                checks++;
                if (bus.cpu_wait !== 1'b1 || bus.cpu_ack !== 1'b0) begin
                    errors++; $display("FAIL wr_wait: got wait %b ack %b expected wait 1 ack 0", bus.cpu_wait, bus.cpu_ack);
                end
            end
            if (c == 1) begin
                checks++;
                if ({bus.cpu_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 16'h1234, 8'hA5}) begin
                    errors++; $display("FAIL wr_ack_mem: got ack %b we %b addr %h data %h expected 1 1 1234 a5", bus.cpu_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            if (c == 3) begin
                checks++;
                if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h1234) begin
                    errors++; $display("FAIL rd_issue: got we %b addr %h expected we 0 addr 1234", bus.mem_we, bus.mem_addr);
                end
            end
            if (c == 4) begin
                checks++;
                if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack: got %b expected 0", bus.cpu_ack); end
            end
            if (c == 5) begin
                checks++;
                if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'hA5) begin
                    errors++; $display("FAIL rd_data: got ack %b data %h expected ack 1 data a5", bus.cpu_ack, bus.cpu_rdata);
                end
            end
            tick;
        end
        idle(4);
    endtask

    task automatic test_contention;
        for (int c = 0; c < 16; c++) begin
            drive(c < 10, 16'h0100 + 16'(c), c == 0 || (c >= 2 && c < 14), c == 0, 16'h2000, 8'h5A);
            #1;
            if (c == 1) begin
                checks++;
                if (bus.cpu_ack !== 1'b1 || bus.mem_we !== 1'b0) begin
                    errors++; $display("FAIL ct_wr_ack: got ack %b we %b expected ack 1 we 0", bus.cpu_ack, bus.mem_we);
                end
            end
            if (c >= 2 && c < 14) begin
                checks++;
                if (bus.cpu_wait !== 1'b1) begin errors++; $display("FAIL ct_wait c%0d: got %b expected 1", c, bus.cpu_wait); end
            end
            if (c >= 9 && c < 13) begin
                checks++;
                if (bus.cpu_starved !== (c == 10 || c == 11)) begin
                    errors++; $display("FAIL ct_starved c%0d: got %b expected %b", c, bus.cpu_starved, (c == 10 || c == 11));
                end
            end
            if (c == 10) begin
                checks++;
                if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0109) begin
                    errors++; $display("FAIL ct_disp_slot: got we %b addr %h expected we 0 addr 0109", bus.mem_we, bus.mem_addr);
                end
            end
            if (c == 11) begin
                checks++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 16'h2000, 8'h5A}) begin
                    errors++; $display("FAIL ct_drain: got we %b addr %h data %h expected 1 2000 5a", bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            if (c == 12) begin
                checks++;
                if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h2000) begin
                    errors++; $display("FAIL ct_rd_issue: got we %b addr %h expected we 0 addr 2000", bus.mem_we, bus.mem_addr);
                end
            end
            if (c == 14) begin
                checks++;
                if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h5A) begin
                    errors++; $display("FAIL ct_rd_data: got ack %b data %h expected ack 1 data 5a", bus.cpu_ack, bus.cpu_rdata);
                end
            end
            tick;
        end
        idle(4);
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 10; c++) begin
            drive(c < 6, 16'h0200 + 16'(c), c == 0 || (c >= 2 && c < 8), 1'b1,
                  c == 0 ? 16'h0010 : 16'h0011, c == 0 ? 8'h11 : 8'h22);
            #1;
            if (c == 1) begin
                checks++;
                if (bus.cpu_ack !== 1'b1 || bus.mem_we !== 1'b0) begin
                    errors++; $display("FAIL bb_first_ack: got ack %b we %b expected ack 1 we 0", bus.cpu_ack, bus.mem_we);
                end
            end
            if (c >= 2 && c < 8) begin
                checks++;
                if (bus.cpu_wait !== 1'b1 || bus.cpu_ack !== 1'b0) begin
                    errors++; $display("FAIL bb_wait c%0d: got wait %b ack %b expected wait 1 ack 0", c, bus.cpu_wait, bus.cpu_ack);
                end
            end
            if (c == 6) begin
                checks++;
                if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL bb_no_early_drain: got %b expected 0", bus.mem_we); end
            end
            if (c == 7) begin
                checks++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 16'h0010, 8'h11}) begin
                    errors++; $display("FAIL bb_drain1: got we %b addr %h data %h expected 1 0010 11", bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            if (c == 8) begin
                checks++;
                if ({bus.cpu_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 16'h0011, 8'h22}) begin
                    errors++; $display("FAIL bb_second: got ack %b we %b addr %h data %h expected 1 1 0011 22", bus.cpu_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            if (c == 9) begin
                checks++;
                if (sram[16'h0010] !== 8'h11 || sram[16'h0011] !== 8'h22) begin
                    errors++; $display("FAIL bb_sram: got %h %h expected 11 22", sram[16'h0010], sram[16'h0011]);
                end
            end
            tick;
        end
        idle(4);
    endtask

    task automatic test_reset_mid_read;
        drive(1'b1, 16'h0005, 1'b1, 1'b0, 16'h1234, 8'h0);
        tick;
        drive(1'b1, 16'h0006, 1'b1, 1'b0, 16'h1234, 8'h0);
        tick;
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h1234, 8'h0);
        tick;
        checks++;
        if (bus.disp_valid !== 1'b1 || bus.mem_addr !== 16'h1234 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL rst_pre_state: got valid %b addr %h we %b expected 1 1234 0", bus.disp_valid, bus.mem_addr, bus.mem_we);
        end
        reset = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0", outs); end
        tick;
        tick;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            checks++;
            if (bus.cpu_ack !== 1'b0 || bus.disp_valid !== 1'b0) begin
                errors++; $display("FAIL rst_stale c%0d: got ack %b valid %b expected 0 0", c, bus.cpu_ack, bus.disp_valid);
            end
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 16'h0, c < 3, 1'b0, 16'h1234, 8'h0);
            #1;
            if (c == 1) begin
                checks++;
                if (bus.mem_addr !== 16'h1234 || bus.mem_we !== 1'b0) begin
                    errors++; $display("FAIL rst_fresh_issue: got addr %h we %b expected 1234 0", bus.mem_addr, bus.mem_we);
                end
            end
            if (c < 3) begin
                checks++;
                if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_fresh_early c%0d: got %b expected 0", c, bus.cpu_ack); end
            end
            if (c == 3) begin
                checks++;
                if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'hA5) begin
                    errors++; $display("FAIL rst_fresh_read: got ack %b data %h expected ack 1 data a5", bus.cpu_ack, bus.cpu_rdata);
                end
            end
            tick;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] <= 8'(i);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        #2;
        test_reset;
        test_display;
        test_write_read;
        test_contention;
        test_back_to_back;
        test_reset_mid_read;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
